// File: rtl/times_table_loader.sv
// times_table_loader
// Fills the 64-word times-table RAM with a*b for a, b in 0..7 on a start request.
// Each product comes from a 3-step shift-add multiply and is then written in one
// cycle, which gives 4 cycles per entry and 257 cycles per full load.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     load request, sampled only while idle
//   busy      high while multiplying or writing
//   done      one-cycle pulse when the load completes
//   mem_we    RAM write enable
//   mem_addr  RAM address {a, b}
//   mem_din   RAM write data a*b
module times_table_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       mem_we,
  output logic [5:0] mem_addr,
  output logic [5:0] mem_din
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] acc_q, acc_d;
  logic [1:0] step_q, step_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       we_q, we_d;
  logic [5:0] addr_q, addr_d;
  logic [5:0] din_q, din_d;

  logic [2:0] op_a;
  logic [3:0] op_b_ext;

  assign op_a     = idx_q[5:3];
  // Zero-extended so any step value indexes in range.
  assign op_b_ext = {1'b0, idx_q[2:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    step_d  = step_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        if (op_b_ext[step_q]) begin
          acc_d = acc_q + ({3'b000, op_a} << step_q);
        end
        if (step_q == 2'd2) begin
          state_d = S_WRITE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_WRITE: begin
        if (idx_q == 6'd63) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 6'd1;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_MULT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered, decoded from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d == S_MULT) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    we_d   = (state_d == S_WRITE);
    addr_d = addr_q;
    din_d  = din_q;
    if (state_d == S_WRITE) begin
      addr_d = idx_d;
      din_d  = acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

endmodule

// File: tb/tb_times_table_loader.sv
module tb_times_table_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [5:0] mem_din;

  times_table_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned cyc;
    int          addr;
    int          data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned done_q[$];
  wr_t         mon_e;

  int   checks     = 0;
  int   failures   = 0;
  int   ram[64];
  int   wr_count   = 0;
  int   done_count = 0;
  logic prev_we    = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: entry n = a*8+b holds a*b; its write is visible after edge E0+4n+3,
  // and the completion pulse follows the edge E0+256.
  task automatic push_load(input int unsigned c0);
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        wr_t e;
        e.cyc  = c0 + 4 * (a * 8 + b) + 3;
        e.addr = a * 8 + b;
        e.data = a * b;
        exp_q.push_back(e);
      end
    end
    done_q.push_back(c0 + 256);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every write or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_count++;
        chk("we_not_back_to_back", int'(prev_we), 0);
        chk("din_le_49", int'(mem_din <= 6'd49), 1);
        chk("we_done_exclusive", int'(done), 0);
        chk("write_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("write_cycle", int'(cyc - mon_e.cyc), 0);
          chk("write_addr", int'(mem_addr), mon_e.addr);
          chk("write_data", int'(mem_din), mon_e.data);
        end
        ram[mem_addr] = int'(mem_din);
      end
      if (done) begin
        done_count++;
        chk("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          chk("done_cycle", int'(cyc), int'(done_q.pop_front()));
        end
      end
      prev_we = mem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < 64; i++) ram[i] = -1;
    wr_count   = 0;
    done_count = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("drain_within_budget", int'(n < max_cycles), 1);
    @(negedge clk);
  endtask

  task automatic check_ram();
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("ram_%0d", i), ram[i], (i / 8) * (i % 8));
    end
  endtask

  task automatic single_load(input bit poke_busy);
    int unsigned c0;
    clear_stats();
    repeat ($urandom_range(1, 8)) @(negedge clk);
    start = 1'b1;
    c0    = cyc + 1;
    push_load(c0);
    @(negedge clk);
    start = 1'b0;
    if (poke_busy) begin
      while (cyc < c0 + 99) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    drain(400);
    chk("write_count", wr_count, 64);
    chk("done_count", done_count, 1);
    chk("busy_after_done", int'(busy), 0);
    check_ram();
    chk("ram_addr0", ram[0], 0);
    chk("ram_addr9", ram[9], 1);
    chk("ram_addr29", ram[29], 15);
    chk("ram_addr42", ram[42], 10);
    chk("ram_addr63", ram[63], 49);
  endtask

  initial begin
    int unsigned c0;
    rst_n = 1'b0;
    start = 1'b0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_din", int'(mem_din), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_we", int'(mem_we), 0);

    // Plain load, then a load with start pokes while busy.
    single_load(1'b0);
    single_load(1'b1);

    // Reset dropped between edges during entry 32.
    clear_stats();
    @(negedge clk);
    start = 1'b1;
    c0    = cyc + 1;
    push_load(c0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 129) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", int'(mem_we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_addr", int'(mem_addr), 0);
    chk("midrst_din", int'(mem_din), 0);
    chk("midrst_writes_before", wr_count, 32);
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    single_load(1'b0);

    // start held high across two back-to-back loads.
    clear_stats();
    repeat ($urandom_range(1, 8)) @(negedge clk);
    start = 1'b1;
    c0    = cyc + 1;
    push_load(c0);
    push_load(c0 + 258);
    while (cyc < c0 + 514) @(negedge clk);
    start = 1'b0;
    drain(100);
    chk("held_write_count", wr_count, 128);
    chk("held_done_count", done_count, 2);
    check_ram();
    repeat (3) @(negedge clk);
    chk("held_idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
